// File: rtl/writeback_arbiter.sv
// Register-file write-port arbiter for ALU/LSU/FPU results, with the pending-write
// scoreboard that decode consults before reading operands.
module writeback_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic        lsu_valid,
  input  logic        fpu_valid,
  output logic        alu_ready,
  output logic        lsu_ready,
  output logic        fpu_ready,
  input  logic [4:0]  alu_reg,
  input  logic [4:0]  lsu_reg,
  input  logic [4:0]  fpu_reg,
  input  logic        alu_f,
  input  logic        lsu_f,
  input  logic        fpu_f,
  input  logic [31:0] alu_data,
  input  logic [31:0] lsu_data,
  input  logic [31:0] fpu_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_reg,
  input  logic        iss_f,
  input  logic [4:0]  q1_reg,
  input  logic [4:0]  q2_reg,
  input  logic        q1_f,
  input  logic        q2_f,
  output logic        q1_busy,
  output logic        q2_busy,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  output logic        writef,
  output logic        err
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {SRC_NONE, SRC_ALU, SRC_LSU, SRC_FPU} src_t;

  src_t              grant;
  logic [CNT_W-1:0]  lsu_cnt_reg, lsu_cnt_next;
  logic [CNT_W-1:0]  fpu_cnt_reg, fpu_cnt_next;
  logic [31:0]       busy_int_reg, busy_fp_reg;
  logic              xfer;
  logic [4:0]        sel_reg;
  logic [31:0]       sel_data;
  logic              sel_f;
  logic              waw_err, orphan_err;

  // Starved sources jump ahead of the ALU; LSU beats FPU when both are starved.
  always_comb begin
    grant = SRC_NONE;
    if (!rst)                                    grant = SRC_NONE;
    else if (lsu_valid && lsu_cnt_reg == LIMIT)  grant = SRC_LSU;
    else if (fpu_valid && fpu_cnt_reg == LIMIT)  grant = SRC_FPU;
    else if (alu_valid)                          grant = SRC_ALU;
    else if (lsu_valid)                          grant = SRC_LSU;
    else if (fpu_valid)                          grant = SRC_FPU;
  end

  assign alu_ready = (grant == SRC_ALU);
  assign lsu_ready = (grant == SRC_LSU);
  assign fpu_ready = (grant == SRC_FPU);
  assign xfer      = (grant != SRC_NONE);

  always_comb begin
    sel_reg  = alu_reg;
    sel_data = alu_data;
    sel_f    = alu_f;
    case (grant)
      SRC_LSU: begin sel_reg = lsu_reg; sel_data = lsu_data; sel_f = lsu_f; end
      SRC_FPU: begin sel_reg = fpu_reg; sel_data = fpu_data; sel_f = fpu_f; end
      default: ;
    endcase
  end

  always_comb begin
    lsu_cnt_next = lsu_cnt_reg;
    fpu_cnt_next = fpu_cnt_reg;
    if (lsu_ready)                                lsu_cnt_next = '0;
    else if (lsu_valid && lsu_cnt_reg != LIMIT)   lsu_cnt_next = lsu_cnt_reg + 1'b1;
    if (fpu_ready)                                fpu_cnt_next = '0;
    else if (fpu_valid && fpu_cnt_reg != LIMIT)   fpu_cnt_next = fpu_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lsu_cnt_reg <= '0;
      fpu_cnt_reg <= '0;
    end else begin
      lsu_cnt_reg <= lsu_cnt_next;
      fpu_cnt_reg <= fpu_cnt_next;
    end
  end

  // Busy bits: an issue in the same cycle as the retiring write keeps the bit set.
  for (genvar gi = 0; gi < 32; gi++) begin : g_busy
    logic set_int, clr_int, set_fp, clr_fp;
    assign set_int = (gi != 0) && iss_valid && !iss_f && (iss_reg == 5'(gi));
    assign clr_int = RegWrite && !writef && (WriteReg == 5'(gi));
    assign set_fp  = iss_valid && iss_f && (iss_reg == 5'(gi));
    assign clr_fp  = RegWrite && writef && (WriteReg == 5'(gi));

    always_ff @(posedge clk) begin
      if (!rst) begin
        busy_int_reg[gi] <= 1'b0;
        busy_fp_reg[gi]  <= 1'b0;
      end else begin
        if (set_int)      busy_int_reg[gi] <= 1'b1;
        else if (clr_int) busy_int_reg[gi] <= 1'b0;
        if (set_fp)       busy_fp_reg[gi]  <= 1'b1;
        else if (clr_fp)  busy_fp_reg[gi]  <= 1'b0;
      end
    end
  end

  assign q1_busy = q1_f ? busy_fp_reg[q1_reg] : busy_int_reg[q1_reg];
  assign q2_busy = q2_f ? busy_fp_reg[q2_reg] : busy_int_reg[q2_reg];

  // Writes to int x0 are never tracked, so they are not treated as orphans.
  assign waw_err    = iss_valid && (iss_f ? busy_fp_reg[iss_reg] : busy_int_reg[iss_reg]);
  assign orphan_err = xfer && (sel_f || sel_reg != 5'd0) &&
                      !(sel_f ? busy_fp_reg[sel_reg] : busy_int_reg[sel_reg]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      RegWrite  <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
      writef    <= 1'b0;
      err       <= 1'b0;
    end else begin
      RegWrite <= xfer;
      if (xfer) begin
        WriteReg  <= sel_reg;
        WriteData <= sel_data;
        writef    <= sel_f;
      end
      if (waw_err || orphan_err) err <= 1'b1;
    end
  end

endmodule
